bus_arbit_rr: RTL and testbench



---
 rtl/bus_arbit_rr.sv | 130 +++++++++++++
 tb/tb_bus_arbit_rr.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/bus_arbit_rr.sv
// bus_arbit_rr -- N-master shared-bus arbiter with registered one-hot grant.
//
// Selects one bus owner per cycle. Arbitration is fixed priority (lowest index
// wins) or round-robin (search starts after the current owner). When nobody
// requests, the bus parks on PARK_ID. The grant is therefore never empty.
// A burst hold limit stops one master from keeping the bus forever while
// others wait.
//
// Optional feature: define ARB_LOCK_EN to add the lock port. While lock is high
// and the owner still requests, the owner keeps the bus past the hold limit.
//
// Ports
//   clk        rising-edge clock
//   reset      asynchronous, active-high reset
//   req        request vector, bit i = master i
//   lock       burst lock from the current owner (ARB_LOCK_EN only)
//   grant      registered one-hot grant
//   grant_id   binary index of the granted master (bus mux select)
//   grant_chg  high for one cycle when the grant changed on the last edge
module bus_arbit_rr #(
    parameter int NUM_M    = 4,
    parameter int MODE     = 1,
    parameter int MAX_HOLD = 8,
    parameter int PARK_ID  = 0
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_M-1:0]         req,
`ifdef ARB_LOCK_EN
    input  logic                     lock,
`endif
    output logic [NUM_M-1:0]         grant,
    output logic [$clog2(NUM_M)-1:0] grant_id,
    output logic                     grant_chg
);

    localparam int ID_W = $clog2(NUM_M);
    // hold_cnt only needs to reach MAX_HOLD-1
    localparam int CW   = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
    localparam logic [ID_W-1:0] PARK    = ID_W'(PARK_ID);
    localparam logic [CW-1:0]   CNT_MAX = (MAX_HOLD > 0) ? CW'(MAX_HOLD - 1) : '0;

    logic [ID_W-1:0]  r_id;
    logic [NUM_M-1:0] r_grant;
    logic             r_chg;
    logic [CW-1:0]    r_cnt;

    logic [NUM_M-1:0] w_others;
    logic             w_own_req;
    logic             w_limit;
    logic             w_lock_hold;
    logic             w_found;
    logic [ID_W-1:0]  w_idx;
    logic [ID_W-1:0]  w_win;
    logic [ID_W-1:0]  w_next_id;
    logic [CW-1:0]    w_next_cnt;

    assign w_own_req = req[r_id];
    // Competitors for a hand-over; the owner is never a candidate because a
    // hand-over only happens when it dropped req or hit its limit.
    assign w_others  = req & ~(NUM_M'(1) << r_id);
    assign w_limit   = (MAX_HOLD != 0) && (r_cnt == CNT_MAX);

`ifdef ARB_LOCK_EN
    assign w_lock_hold = lock;
`else
    assign w_lock_hold = 1'b0;
`endif

    // Winner among the other requesters
    always_comb begin
        w_win   = r_id;
        w_found = 1'b0;
        w_idx   = '0;
        if (MODE == 0) begin
            // descending scan so the lowest set index is written last
            for (int i = NUM_M - 1; i >= 0; i--) begin
                if (w_others[ID_W'(i)]) w_win = ID_W'(i);
            end
        end else begin
            for (int k = 1; k < NUM_M; k++) begin
                w_idx = ID_W'((int'(r_id) + k) % NUM_M);
                if (!w_found && w_others[w_idx]) begin
                    w_win   = w_idx;
                    w_found = 1'b1;
                end
            end
        end
    end

    // Ownership decision
    always_comb begin
        w_next_id  = r_id;
        w_next_cnt = r_cnt;
        if (req == '0) begin
            w_next_id  = PARK;
            w_next_cnt = '0;
        end else if (w_own_req && w_lock_hold) begin
            // locked burst: keep owner, counter frozen
            w_next_id = r_id;
        end else if (w_own_req && !w_limit) begin
            w_next_cnt = (MAX_HOLD == 0) ? '0 : r_cnt + CW'(1);
        end else if (w_own_req && (w_others == '0)) begin
            // limit reached but nobody else waiting: keep, counter saturated
            w_next_id = r_id;
        end else begin
            w_next_id  = w_win;
            w_next_cnt = '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_id    <= PARK;
            r_grant <= NUM_M'(1) << PARK;
            r_chg   <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_id    <= w_next_id;
            r_grant <= NUM_M'(1) << w_next_id;
            r_chg   <= (w_next_id != r_id);
            r_cnt   <= w_next_cnt;
        end
    end

    assign grant     = r_grant;
    assign grant_id  = r_id;
    assign grant_chg = r_chg;

endmodule

// File: tb/tb_bus_arbit_rr.sv
module tb_bus_arbit_rr;

    localparam int ND = 4;
    // per-instance configuration: MODE, MAX_HOLD, PARK_ID
    localparam int P_MODE [ND] = '{1, 1, 0, 1};
    localparam int P_HOLD [ND] = '{8, 1, 8, 2};
    localparam int P_PARK [ND] = '{0, 0, 2, 0};

    logic       clk = 1'b0;
    logic       reset;
    logic       lock;
    logic [3:0] req [ND];
    logic [3:0] gnt [ND];
    logic [1:0] gid [ND];
    logic       chg [ND];

    always #5 clk = ~clk;

    bus_arbit_rr #(.NUM_M(4), .MODE(1), .MAX_HOLD(8), .PARK_ID(0)) u_a0 (
        .clk(clk), .reset(reset), .req(req[0]),
`ifdef ARB_LOCK_EN
        .lock(1'b0),
`endif
        .grant(gnt[0]), .grant_id(gid[0]), .grant_chg(chg[0]));

    bus_arbit_rr #(.NUM_M(4), .MODE(1), .MAX_HOLD(1), .PARK_ID(0)) u_a1 (
        .clk(clk), .reset(reset), .req(req[1]),
`ifdef ARB_LOCK_EN
        .lock(1'b0),
`endif
        .grant(gnt[1]), .grant_id(gid[1]), .grant_chg(chg[1]));

    bus_arbit_rr #(.NUM_M(4), .MODE(0), .MAX_HOLD(8), .PARK_ID(2)) u_a2 (
        .clk(clk), .reset(reset), .req(req[2]),
`ifdef ARB_LOCK_EN
        .lock(1'b0),
`endif
        .grant(gnt[2]), .grant_id(gid[2]), .grant_chg(chg[2]));

    bus_arbit_rr #(.NUM_M(4), .MODE(1), .MAX_HOLD(2), .PARK_ID(0)) u_a3 (
        .clk(clk), .reset(reset), .req(req[3]),
`ifdef ARB_LOCK_EN
        .lock(lock),
`endif
        .grant(gnt[3]), .grant_id(gid[3]), .grant_chg(chg[3]));

    typedef struct {
        int         d;
        string      tag;
        logic [3:0] g;
        logic       has_id;
        logic [1:0] id;
        logic       c;
    } exp_t;

    exp_t sb[$];
    int   n_chk  = 0;
    int   n_pass = 0;
    int   m_own [ND];
    int   m_cnt [ND];

    task automatic chk(input string tag, input int obs, input int exp);
        n_chk++;
        if (obs == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    endtask

    // reference arbitration: first candidate in search order, owner last
    function automatic int pick(input int mode, input int own, input logic [3:0] cand);
        int w;
        w = -1;
        if (mode == 0) begin
            for (int i = 3; i >= 0; i--) if (cand[i]) w = i;
        end else begin
            for (int k = 4; k >= 1; k--) if (cand[(own + k) % 4]) w = (own + k) % 4;
        end
        return w;
    endfunction

    task automatic model_push(input int d, input logic [3:0] r, input logic lk, input string tag);
        int         own, cnt, nown, ncnt, hl;
        logic [3:0] oth;
        exp_t       e;
        own  = m_own[d];
        cnt  = m_cnt[d];
        hl   = P_HOLD[d];
        oth  = r & ~(4'b0001 << own);
        nown = own;
        ncnt = cnt;
        if (r == 4'b0000) begin
            nown = P_PARK[d];
            ncnt = 0;
        end else if (r[own] && lk) begin
            nown = own;
        end else if (r[own] && (hl == 0 || cnt < hl - 1)) begin
            ncnt = (hl == 0) ? 0 : cnt + 1;
        end else if (r[own] && oth == 4'b0000) begin
            nown = own;
        end else begin
            nown = pick(P_MODE[d], own, oth);
            ncnt = 0;
        end
        e.d = d; e.tag = tag; e.g = 4'b0001 << nown; e.has_id = 1'b1;
        e.id = 2'(nown); e.c = (nown != own);
        sb.push_back(e);
        m_own[d] = nown;
        m_cnt[d] = ncnt;
    endtask

    task automatic exp_const(input int d, input string tag, input logic [3:0] g, input logic c);
        exp_t e;
        e.d = d; e.tag = tag; e.g = g; e.has_id = 1'b0; e.id = 2'b00; e.c = c;
        sb.push_back(e);
    endtask

    task automatic drain();
        exp_t e;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            chk($sformatf("%s.u%0d/grant", e.tag, e.d), int'(gnt[e.d]), int'(e.g));
            chk($sformatf("%s.u%0d/chg", e.tag, e.d), int'(chg[e.d]), int'(e.c));
            if (e.has_id) begin
                chk($sformatf("%s.u%0d/id", e.tag, e.d), int'(gid[e.d]), int'(e.id));
                chk($sformatf("%s.u%0d/onehot", e.tag, e.d), $countones(gnt[e.d]), 1);
            end
        end
    endtask

    task automatic cycle(input logic [3:0] r0, input logic [3:0] r1, input logic [3:0] r2,
                         input logic [3:0] r3, input logic lk, input string tag);
        logic lk_eff;
`ifdef ARB_LOCK_EN
        lk_eff = lk;
`else
        lk_eff = 1'b0;
`endif
        req[0] = r0; req[1] = r1; req[2] = r2; req[3] = r3; lock = lk;
        model_push(0, r0, 1'b0, tag);
        model_push(1, r1, 1'b0, tag);
        model_push(2, r2, 1'b0, tag);
        model_push(3, r3, lk_eff, tag);
        @(posedge clk);
        #1;
        drain();
    endtask

    // reset asserted between edges; outputs must drop to park immediately
    task automatic do_reset(input string tag);
        exp_t e;
        #2 reset = 1'b1;
        #1;
        for (int d = 0; d < ND; d++) begin
            m_own[d] = P_PARK[d];
            m_cnt[d] = 0;
            e.d = d; e.tag = tag; e.g = 4'b0001 << P_PARK[d]; e.has_id = 1'b1;
            e.id = 2'(P_PARK[d]); e.c = 1'b0;
            sb.push_back(e);
        end
        drain();
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [3:0] eg;
        reset = 1'b1;
        lock  = 1'b0;
        for (int d = 0; d < ND; d++) begin
            req[d]   = 4'b0000;
            m_own[d] = P_PARK[d];
            m_cnt[d] = 0;
        end
        repeat (2) @(posedge clk);
        #1;
        do_reset("rst");

        // T2: MAX_HOLD=1 round-robin rotates every cycle
        eg = 4'b0001;
        for (int k = 0; k < 8; k++) begin
            eg = {eg[2:0], eg[3]};
            exp_const(1, "T2", eg, 1'b1);
            cycle(4'b0000, 4'b1111, 4'b0000, 4'b0000, 1'b0, "T2");
        end

        // T6: owner M3 drops while M1/M2 raise -> wrap search picks M1
        exp_const(0, "T6", 4'b1000, 1'b1);
        cycle(4'b1000, 4'b0000, 4'b0000, 4'b0000, 1'b0, "T6");
        exp_const(0, "T6", 4'b0010, 1'b1);
        cycle(4'b0110, 4'b0000, 4'b0000, 4'b0000, 1'b0, "T6");

        // T4: parked on M2
        exp_const(2, "T4", 4'b0100, 1'b0);
        cycle(4'b0000, 4'b0000, 4'b0100, 4'b0000, 1'b0, "T4");
        exp_const(2, "T4", 4'b0100, 1'b0);
        cycle(4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0, "T4");
        exp_const(2, "T4", 4'b0001, 1'b1);
        cycle(4'b0000, 4'b0000, 4'b0001, 4'b0000, 1'b0, "T4");
        cycle(4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0, "T4");

        // T3: fixed priority, hold limit 8 with two contenders
        for (int k = 1; k <= 17; k++) begin
            eg = (k <= 8 || k == 17) ? 4'b0001 : 4'b0010;
            exp_const(2, "T3", eg, (k == 1 || k == 9 || k == 17));
            cycle(4'b0000, 4'b0000, 4'b0011, 4'b0000, 1'b0, "T3");
        end

`ifdef ARB_LOCK_EN
        // T5: lock holds M1 past its limit; release hands over at once
        cycle(4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0, "T5");
        for (int k = 0; k < 3; k++) begin
            exp_const(3, "T5", 4'b0010, (k == 0));
            cycle(4'b0000, 4'b0000, 4'b0000, 4'b0010, 1'b0, "T5");
        end
        for (int k = 0; k < 10; k++) begin
            exp_const(3, "T5", 4'b0010, 1'b0);
            cycle(4'b0000, 4'b0000, 4'b0000, 4'b0011, 1'b1, "T5");
        end
        exp_const(3, "T5", 4'b0001, 1'b1);
        cycle(4'b0000, 4'b0000, 4'b0000, 4'b0011, 1'b0, "T5");
`endif

        // T1: reset in the middle of a busy run
        for (int k = 0; k < 3; k++)
            cycle(4'b1111, 4'b1111, 4'b1111, 4'b1111, 1'b0, "T1pre");
        do_reset("T1");
        exp_const(0, "T1post", 4'b0001, 1'b0);
        cycle(4'b1111, 4'b1111, 4'b1111, 4'b1111, 1'b0, "T1post");

        // random traffic against the reference model
        for (int k = 0; k < 400; k++) begin
            cycle(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                  4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                  ($urandom_range(0, 3) == 0), "rnd");
            if (k == 200) do_reset("rnd_rst");
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
